// File: rtl/de1_input_pkg.sv
// Shared sizes and reset-sequencer state encoding for the DE1 input conditioner.
package de1_input_pkg;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned NUM_SW   = 10;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/de1_input_conditioner_debounce_bit.sv
// One input bit: two-flop synchronizer, optional inversion, stability counter
// and the debounced level register.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        SYNC_RESET_VAL  = 1'b0,
  parameter logic        INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             synced_c;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= SYNC_RESET_VAL;
      sync2 <= SYNC_RESET_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign synced_c = sync2 ^ INVERT;

  // Any bounce back to the current level restarts the stability count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (synced_c == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= synced_c;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/de1_input_conditioner.sv
// DE1 board input conditioner: debounced keys/switches, key press pulses and a
// stretched core reset. Define INPUT_COND_PRESS_PULSE_EN to build key_press.
module de1_input_conditioner
  import de1_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RESET_HOLD      = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   SW,
  output logic [NUM_KEYS-1:0] key_db,
  output logic [NUM_SW-1:0]   sw_db,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                sys_reset
);

  localparam int unsigned      HOLD_W    = $clog2(RESET_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  seq_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              key0_rise_c;

  // Keys idle high on the board, so their synchronizers reset to 1 and invert.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_RESET_VAL (1'b1),
      .INVERT         (1'b1)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (KEY[i]),
      .level(key_db[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_RESET_VAL (1'b0),
      .INVERT         (1'b0)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (SW[i]),
      .level(sw_db[i])
    );
  end

`ifdef INPUT_COND_PRESS_PULSE_EN
  logic [NUM_KEYS-1:0] key_db_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_db_q  <= '0;
      key_press <= '0;
    end else begin
      key_db_q  <= key_db;
      key_press <= key_db & ~key_db_q;
    end
  end

  assign key0_rise_c = key_db[0] & ~key_db_q[0];
`else
  logic key0_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key0_q <= 1'b0;
    end else begin
      key0_q <= key_db[0];
    end
  end

  assign key_press   = '0;
  assign key0_rise_c = key_db[0] & ~key0_q;
`endif

  // Reset sequencer: a KEY[0] press (re)starts a full hold interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      sys_reset <= 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (key0_rise_c) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            hold_cnt  <= '0;
            sys_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (key0_rise_c) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            sys_reset <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de1_input_conditioner.sv
// Self-checking bench for de1_input_conditioner (DEBOUNCE_CYCLES=8, RESET_HOLD=16).
module tb_de1_input_conditioner;

  localparam int unsigned DEB  = 8;
  localparam int unsigned HOLD = 16;
  localparam int unsigned NB   = 14;
`ifdef INPUT_COND_PRESS_PULSE_EN
  localparam int EXP_PULSES = 1;
`else
  localparam int EXP_PULSES = 0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] KEY   = 4'hF;
  logic [9:0] SW    = '0;
  logic [3:0] key_db;
  logic [9:0] sw_db;
  logic [3:0] key_press;
  logic       sys_reset;

  int checks = 0;
  int errors = 0;

  // Model: pin history (active-high, keys already inverted), newest first.
  logic [NB-1:0] hist [DEB+1];
  logic [NB-1:0] m_db;
  logic [NB-1:0] m_db_prev;
  logic [3:0]    m_press;
  int            m_rem;

  de1_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_HOLD     (HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .KEY      (KEY),
    .SW       (SW),
    .key_db   (key_db),
    .sw_db    (sw_db),
    .key_press(key_press),
    .sys_reset(sys_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A level flips once the synchronized input has differed from it on each of
  // the last DEB edges; synchronized value at an edge is the pin two edges back.
  task automatic model_step();
    logic [NB-1:0] next_db;
    bit            all_differ;
    if (reset) begin
      for (int k = 0; k <= DEB; k++) hist[k] = '0;
      m_db      = '0;
      m_db_prev = '0;
      m_press   = '0;
      m_rem     = HOLD;
    end else begin
      next_db = m_db;
      for (int b = 0; b < NB; b++) begin
        all_differ = 1'b1;
        for (int k = 1; k <= DEB; k++)
          if (hist[k][b] == m_db[b]) all_differ = 1'b0;
        if (all_differ) next_db[b] = hist[1][b];
      end
      m_press = m_db[3:0] & ~m_db_prev[3:0];
      if (m_press[0]) m_rem = HOLD;
      else if (m_rem > 0) m_rem--;
      for (int k = DEB; k >= 1; k--) hist[k] = hist[k-1];
      hist[0]   = {SW, ~KEY};
      m_db_prev = m_db;
      m_db      = next_db;
    end
  endtask

  task automatic compare_all();
    check("key_db", int'(key_db), int'(m_db[3:0]));
    check("sw_db", int'(sw_db), int'(m_db[NB-1:4]));
    check("key_press", int'(key_press), (EXP_PULSES != 0) ? int'(m_press) : 0);
    check("sys_reset", int'(sys_reset), (m_rem > 0) ? 1 : 0);
  endtask

  // One clock: model and compare at the falling edge, inputs change 1 ns later.
  task automatic tick();
    @(negedge clk);
    model_step();
    compare_all();
    #1;
  endtask

  function automatic bit probe(input int sel);
    case (sel)
      0:       return sw_db[3];
      1:       return key_db[2];
      2:       return key_db[0];
      3:       return sw_db[9];
      default: return ~sys_reset;
    endcase
  endfunction

  task automatic ticks_until(input int sel, input int budget, output int n);
    n = 0;
    while (!probe(sel) && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    bit ok;

    repeat (3) tick();
    check("rst_sys_reset", int'(sys_reset), 1);
    check("rst_key_db", int'(key_db), 0);
    check("rst_sw_db", int'(sw_db), 0);
    check("rst_key_press", int'(key_press), 0);

    reset = 1'b0;
    ticks_until(4, 100, n);
    check("hold_len_after_reset", n, 16);

    SW[3] = 1'b1;
    ticks_until(0, 50, n);
    check("sw3_latency", n, 10);
    check("sw_db_only_bit3", int'(sw_db), 8);
    check("key_db_idle", int'(key_db), 0);

    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) KEY[2] = ~KEY[2];
      tick();
      if (key_db[2]) ok = 1'b0;
    end
    check("key2_glitch_ignored", int'(ok), 1);

    KEY[2] = 1'b0;
    pulses = 0;
    n = 0;
    while (!key_db[2] && n < 50) begin
      tick();
      n++;
      pulses += int'(key_press[2]);
    end
    check("key2_latency", n, 10);
    repeat (20) begin
      tick();
      pulses += int'(key_press[2]);
    end
    check("key2_press_pulses", pulses, EXP_PULSES);
    KEY[2] = 1'b1;
    repeat (20) tick();

    check("in_run", int'(sys_reset), 0);
    KEY[0] = 1'b0;
    ticks_until(2, 50, n);
    check("key0_latency", n, 10);
    check("sys_reset_not_yet", int'(sys_reset), 0);
    tick();
    check("sys_reset_rose", int'(sys_reset), 1);
    ticks_until(4, 50, n);
    check("key_reset_len", n, 16);
    KEY[0] = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      tick();
      if (sys_reset) ok = 1'b0;
    end
    check("release_no_reset", int'(ok), 1);

    // Key pressed at release: debounced at edge 10, seen by the sequencer at
    // edge 11 (hold count 10), then a fresh 16-cycle hold.
    reset = 1'b1;
    repeat (2) tick();
    reset  = 1'b0;
    KEY[0] = 1'b0;
    ticks_until(4, 100, n);
    check("hold_restart_len", n, DEB + 3 + HOLD);
    KEY[0] = 1'b1;
    repeat (30) tick();

    SW[9] = 1'b1;
    repeat (7) tick();
    check("sw9_not_yet", int'(sw_db[9]), 0);
    reset = 1'b1;
    tick();
    check("mid_rst_sw_db", int'(sw_db), 0);
    check("mid_rst_key_db", int'(key_db), 0);
    check("mid_rst_sys_reset", int'(sys_reset), 1);
    reset = 1'b0;
    ticks_until(3, 50, n);
    check("sw9_full_latency", n, 10);

    for (int c = 0; c < 2500; c++) begin
      int r;
      r = int'($urandom_range(0, 63));
      if (r < 4) KEY[$urandom_range(0, 3)] ^= 1'b1;
      else if (r < 10) SW[$urandom_range(0, 9)] ^= 1'b1;
      reset = ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0;
      tick();
    end
    reset = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
